// File: rtl/averager_accumulator.sv
// averager_accumulator: per-bin read-modify-write accumulator behind the averager
// address counter. Each enabled sample adds into (or, with init, overwrites) its
// bin. Samples flagged with wen also emit the completed sum to the result BRAM port.
// Pipeline: S0 input register, S1 RAM read, S2 sum register, then the RAM write
// and the result register. Hazards are covered by forwarding from S2 and S3 into S1.
// ACC_WIDTH must be >= DATA_WIDTH.
module averager_accumulator #(
    parameter int FAST_COUNT_WIDTH = 13,
    parameter int DATA_WIDTH       = 14,
    parameter int ACC_WIDTH        = 32
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clken,
    input  logic [DATA_WIDTH-1:0]       din,
    input  logic [FAST_COUNT_WIDTH+1:0] address,
    input  logic                        init,
    input  logic                        wen,
    output logic [FAST_COUNT_WIDTH+1:0] result_addr,
    output logic [ACC_WIDTH-1:0]        result_data,
    output logic                        result_we
);

    localparam int DEPTH = 1 << FAST_COUNT_WIDTH;

    typedef logic [FAST_COUNT_WIDTH-1:0] bin_t;
    typedef logic [ACC_WIDTH-1:0]        acc_t;

    acc_t mem [DEPTH];

    // S0: registered input sample
    logic s0_valid;
    logic s0_init;
    logic s0_wen;
    bin_t s0_bin;
    acc_t s0_din;

    // S1: sample aligned with RAM read data
    logic s1_valid;
    logic s1_init;
    logic s1_wen;
    bin_t s1_bin;
    acc_t s1_din;
    acc_t ram_q;

    // S2: computed sum, written to RAM on the next edge
    logic s2_valid;
    logic s2_wen;
    bin_t s2_bin;
    acc_t s2_sum;

    // S3: the write committed on the previous edge, still invisible to a read-first RAM read
    logic s3_valid;
    bin_t s3_bin;
    acc_t s3_sum;

    acc_t din_ext;
    acc_t acc_prev;
    acc_t sum_next;

    // The two byte-offset address bits carry no bin information.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^address[1:0];

    assign din_ext = ACC_WIDTH'($signed(din));

    // Capture the incoming sample; clken becomes the stage valid bit
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s0_valid <= 1'b0;
            s0_init  <= 1'b0;
            s0_wen   <= 1'b0;
            s0_bin   <= '0;
            s0_din   <= '0;
        end else begin
            s0_valid <= clken;
            if (clken) begin
                s0_init <= init;
                s0_wen  <= wen;
                s0_bin  <= address[FAST_COUNT_WIDTH+1:2];
                s0_din  <= din_ext;
            end
        end
    end

    // Synchronous RAM read for the S0 bin
    always_ff @(posedge clk) begin
        ram_q <= mem[s0_bin];
    end

    // Advance the sample alongside its read data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_init  <= 1'b0;
            s1_wen   <= 1'b0;
            s1_bin   <= '0;
            s1_din   <= '0;
        end else begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_init <= s0_init;
                s1_wen  <= s0_wen;
                s1_bin  <= s0_bin;
                s1_din  <= s0_din;
            end
        end
    end

    // Pick the newest value for the bin (S2 over S3 over RAM) and form the sum
    always_comb begin
        acc_prev = ram_q;
        if (s3_valid && (s3_bin == s1_bin)) begin
            acc_prev = s3_sum;
        end
        if (s2_valid && (s2_bin == s1_bin)) begin
            acc_prev = s2_sum;
        end
        sum_next = s1_init ? s1_din : (acc_prev + s1_din);
    end

    // Register the sum for the RAM write and result emission
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s2_valid <= 1'b0;
            s2_wen   <= 1'b0;
            s2_bin   <= '0;
            s2_sum   <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_wen <= s1_wen;
                s2_bin <= s1_bin;
                s2_sum <= sum_next;
            end
        end
    end

    // RAM write of the completed sum; bubbles write nothing
    always_ff @(posedge clk) begin
        if (s2_valid) begin
            mem[s2_bin] <= s2_sum;
        end
    end

    // Remember the just-committed write for forwarding, and drive the result port
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s3_valid    <= 1'b0;
            s3_bin      <= '0;
            s3_sum      <= '0;
            result_we   <= 1'b0;
            result_addr <= '0;
            result_data <= '0;
        end else begin
            s3_valid  <= s2_valid;
            result_we <= s2_valid & s2_wen;
            if (s2_valid) begin
                s3_bin <= s2_bin;
                s3_sum <= s2_sum;
            end
            if (s2_valid && s2_wen) begin
                result_addr <= {s2_bin, 2'b00};
                result_data <= s2_sum;
            end
        end
    end

endmodule

// File: tb/tb_averager_accumulator.sv
// Testbench for averager_accumulator: a 32-bit and a 16-bit accumulator instance
// see identical stimulus. A sequential per-bin reference model pushes expected
// result words, tagged with their due cycle, into one queue per instance.
module tb_averager_accumulator;

    localparam int FCW   = 13;
    localparam int DW    = 14;
    localparam int NBINS = 1 << FCW;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic                  clken;
    logic signed [DW-1:0]  din;
    logic [FCW+1:0]        address;
    logic                  init;
    logic                  wen;

    logic [FCW+1:0] ra32, ra16;
    logic [31:0]    rd32;
    logic [15:0]    rd16;
    logic           we32, we16;

    averager_accumulator #(.FAST_COUNT_WIDTH(FCW), .DATA_WIDTH(DW), .ACC_WIDTH(32)) dut32 (
        .clk(clk), .resetn(resetn), .clken(clken), .din(din), .address(address),
        .init(init), .wen(wen), .result_addr(ra32), .result_data(rd32), .result_we(we32)
    );

    averager_accumulator #(.FAST_COUNT_WIDTH(FCW), .DATA_WIDTH(DW), .ACC_WIDTH(16)) dut16 (
        .clk(clk), .resetn(resetn), .clken(clken), .din(din), .address(address),
        .init(init), .wen(wen), .result_addr(ra16), .result_data(rd16), .result_we(we16)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             due;
        logic [FCW+1:0] addr;
        logic [31:0]    data;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t e32, e16;

    logic [31:0] model  [NBINS];
    bit          mvalid [NBINS];

    int n_checks = 0;
    int n_fail   = 0;
    int n_push   = 0;
    int n_pop32  = 0;
    int n_pop16  = 0;

    // Scoreboard for the 32-bit instance
    always @(negedge clk) begin
        if (we32 === 1'b1) begin
            n_checks++;
            n_pop32++;
            if (q32.size() == 0) begin
                n_fail++;
                $display("FAIL acc32_unexpected_we cyc=%0d addr=%h data=%h required no write", cyc, ra32, rd32);
            end else begin
                e32 = q32.pop_front();
                if (ra32 !== e32.addr || rd32 !== e32.data || cyc !== e32.due) begin
                    n_fail++;
                    $display("FAIL acc32_result cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                             cyc, ra32, rd32, e32.due, e32.addr, e32.data);
                end
            end
        end else if (q32.size() > 0 && q32[0].due < cyc) begin
            n_checks++;
            n_fail++;
            e32 = q32.pop_front();
            $display("FAIL acc32_missing cyc=%0d no write, required cyc=%0d addr=%h data=%h",
                     cyc, e32.due, e32.addr, e32.data);
        end
    end

    // Scoreboard for the 16-bit instance
    always @(negedge clk) begin
        if (we16 === 1'b1) begin
            n_checks++;
            n_pop16++;
            if (q16.size() == 0) begin
                n_fail++;
                $display("FAIL acc16_unexpected_we cyc=%0d addr=%h data=%h required no write", cyc, ra16, rd16);
            end else begin
                e16 = q16.pop_front();
                if (ra16 !== e16.addr || rd16 !== e16.data[15:0] || cyc !== e16.due) begin
                    n_fail++;
                    $display("FAIL acc16_result cyc=%0d addr=%h data=%h required cyc=%0d addr=%h data=%h",
                             cyc, ra16, rd16, e16.due, e16.addr, e16.data[15:0]);
                end
            end
        end else if (q16.size() > 0 && q16[0].due < cyc) begin
            n_checks++;
            n_fail++;
            e16 = q16.pop_front();
            $display("FAIL acc16_missing cyc=%0d no write, required cyc=%0d addr=%h data=%h",
                     cyc, e16.due, e16.addr, e16.data[15:0]);
        end
    end

    // Drive one slot; an enabled sample updates the model and queues its result if wen
    task automatic step(input bit ce, input int d, input int b, input bit i, input bit w);
        logic [31:0]        s;
        logic signed [31:0] e;
        logic [1:0]         lsb;
        exp_t               x;
        lsb     = 2'($urandom);
        clken   = ce;
        din     = d[DW-1:0];
        address = {b[FCW-1:0], lsb};
        init    = i;
        wen     = w;
        if (ce && resetn) begin
            e = din;
            s = i ? e : (model[b] + e);
            model[b]  = s;
            mvalid[b] = 1'b1;
            if (w) begin
                x.due  = cyc + 4;
                x.addr = {b[FCW-1:0], 2'b00};
                x.data = s;
                q32.push_back(x);
                x.data = {16'h0000, s[15:0]};
                q16.push_back(x);
                n_push++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        clken   = 1'b0;
        din     = '0;
        address = '0;
        init    = 1'b0;
        wen     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (we32 !== 1'b0 || ra32 !== '0 || rd32 !== '0) begin
            n_fail++;
            $display("FAIL reset_acc32 we=%b addr=%h data=%h required 0 0 0", we32, ra32, rd32);
        end
        n_checks++;
        if (we16 !== 1'b0 || ra16 !== '0 || rd16 !== '0) begin
            n_fail++;
            $display("FAIL reset_acc16 we=%b addr=%h data=%h required 0 0 0", we16, ra16, rd16);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int p0;
        p0 = n_pop32;
        for (int p = 0; p < 3; p++)
            for (int b = 0; b < 4; b++) step(1'b1, 5, b, p == 0, p == 2);
        idle(8);
        n_checks++;
        if (n_pop32 - p0 !== 4) begin
            n_fail++;
            $display("FAIL basic_count writes=%0d required 4", n_pop32 - p0);
        end
    endtask

    task automatic test_signed();
        int p0;
        p0 = n_pop32;
        for (int p = 0; p < 3; p++) step(1'b1, -8192, 0, p == 0, p == 2);
        idle(8);
        n_checks++;
        if (n_pop32 - p0 !== 1 || rd32 !== 32'hFFFFA000) begin
            n_fail++;
            $display("FAIL signed_sum writes=%0d data=%h required 1 FFFFA000", n_pop32 - p0, rd32);
        end
    endtask

    task automatic test_bubbles();
        bit pat [5];
        int sent, slot, nb, b, ps, p0;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        for (int cm = 1; cm <= 2; cm++) begin
            sent = 0;
            slot = 0;
            nb   = cm + 1;
            p0   = n_pop32;
            while (sent < 5 * nb) begin
                if (pat[slot % 5]) begin
                    b  = sent % nb;
                    ps = sent / nb;
                    step(1'b1, b + 1, b, ps == 0, ps == 4);
                    sent++;
                end else begin
                    // disabled slot with wen/init set must be ignored
                    step(1'b0, int'($urandom_range(0, 100)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
                end
                slot++;
            end
            idle(8);
            n_checks++;
            if (n_pop32 - p0 !== nb) begin
                n_fail++;
                $display("FAIL bubbles_count cm=%0d writes=%0d required %0d", cm, n_pop32 - p0, nb);
            end
        end
    endtask

    task automatic test_overflow();
        int p0;
        p0 = n_pop16;
        for (int p = 0; p < 10; p++) step(1'b1, 8191, 7, p == 0, 1'b1);
        idle(8);
        n_checks++;
        if (n_pop16 - p0 !== 10 || rd16 !== 16'h3FF6) begin
            n_fail++;
            $display("FAIL overflow_wrap writes=%0d data=%h required 10 3FF6", n_pop16 - p0, rd16);
        end
    endtask

    task automatic test_init_wen();
        int p0;
        p0 = n_pop32;
        for (int b = 0; b < 4; b++) step(1'b1, 123, b, 1'b1, 1'b1);
        idle(8);
        n_checks++;
        if (n_pop32 - p0 !== 4 || rd32 !== 32'd123) begin
            n_fail++;
            $display("FAIL init_wen writes=%0d data=%0d required 4 123", n_pop32 - p0, rd32);
        end
    endtask

    task automatic test_back_to_back();
        int b, p0, n0;
        bit ce, i, w;
        p0 = n_pop32;
        n0 = n_push;
        for (int k = 0; k < 400; k++) begin
            b  = int'($urandom_range(0, 2));
            ce = ($urandom_range(0, 3) != 0);
            i  = !mvalid[b] || ($urandom_range(0, 15) == 0);
            w  = ($urandom_range(0, 2) == 0);
            step(ce, int'($urandom_range(0, 16383)) - 8192, b, i, w);
        end
        idle(8);
        n_checks++;
        if (n_pop32 - p0 !== n_push - n0) begin
            n_fail++;
            $display("FAIL b2b_count writes=%0d required %0d", n_pop32 - p0, n_push - n0);
        end
    endtask

    task automatic test_reset_midrun();
        int p0;
        for (int b = 0; b < 3; b++) step(1'b1, 100 + b, b, 1'b1, 1'b1);
        resetn = 1'b0;
        q32.delete();
        q16.delete();
        p0    = n_pop32;
        clken = 1'b1;
        wen   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (we32 !== 1'b0 || we16 !== 1'b0) begin
                n_fail++;
                $display("FAIL midrun_reset_we k=%0d we32=%b we16=%b required 0 0", k, we32, we16);
            end
            @(posedge clk);
            #1;
        end
        resetn = 1'b1;
        for (int b = 0; b < 3; b++) mvalid[b] = 1'b0;
        idle(8);
        n_checks++;
        if (n_pop32 !== p0) begin
            n_fail++;
            $display("FAIL midrun_discard writes=%0d required 0", n_pop32 - p0);
        end
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < 3; b++) step(1'b1, 7 * (b + 1), b, p == 0, p == 1);
        idle(8);
        n_checks++;
        if (n_pop32 - p0 !== 3 || rd32 !== 32'd42) begin
            n_fail++;
            $display("FAIL midrun_rerun writes=%0d data=%0d required 3 42", n_pop32 - p0, rd32);
        end
    endtask

    initial begin
        for (int k = 0; k < NBINS; k++) begin
            model[k]  = '0;
            mvalid[k] = 1'b0;
        end
        test_reset();
        test_basic();
        test_signed();
        test_bubbles();
        test_overflow();
        test_init_wen();
        test_back_to_back();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
